// File: rtl/memory_dbus_ctrl_if.sv
// Data-bus handshake bundle between the M-stage controller and the memory system.
// The controller drives the request side; the memory returns addr_ok/data_ok/data.
interface memory_dbus_ctrl_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    logic                dreq_valid;
    logic [ADDR_W-1:0]   dreq_addr;
    logic [1:0]          dreq_size;
    logic [XLEN/8-1:0]   dreq_strobe;
    logic [XLEN-1:0]     dreq_data;
    logic                dresp_addr_ok;
    logic                dresp_data_ok;
    logic [XLEN-1:0]     dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/memory_dbus_ctrl.sv
// Memory-stage data-bus request controller. Issues one load/store per M-stage
// instruction, stalls the pipeline until it completes and hands the raw read
// doubleword to writeback (size/sign extraction happens there).
//
// state | meaning
// IDLE  | no access in flight; waiting for an M-stage memory op
// REQ   | request presented on the bus, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok
// DONE  | access finished (or rejected as misaligned); wait for pipe_advance
module memory_dbus_ctrl #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_msize,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    input  logic                  pipe_advance,
    memory_dbus_ctrl_if.master    dbus,
    output logic                  mem_stall,
    output logic [XLEN-1:0]       rd_raw,
    output logic                  misalign
);
    localparam int SW = XLEN / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          ofs;
    logic                misalign_calc;
    logic [SW-1:0]       strobe_base;
    logic [SW-1:0]       strobe_calc;
    logic [XLEN-1:0]     data_calc;
    logic                issue;
    logic                reject;
    logic                capture;

    logic [ADDR_W-1:0]   addr_r;
    logic [1:0]          size_r;
    logic [SW-1:0]       strobe_r;
    logic [XLEN-1:0]     data_r;
    logic                write_r;
    logic                misalign_r;
    logic [XLEN-1:0]     rd_raw_r;

    assign ofs = req_addr[2:0];

    // Decode size alignment, byte enables and lane-shifted store data from the live request.
    always_comb begin
        misalign_calc = 1'b0;
        strobe_base   = '1;
        case (req_msize)
            2'd0: strobe_base = SW'(8'h01);
            2'd1: begin
                strobe_base   = SW'(8'h03);
                misalign_calc = ofs[0];
            end
            2'd2: begin
                strobe_base   = SW'(8'h0F);
                misalign_calc = |ofs[1:0];
            end
            default: begin
                strobe_base   = '1;
                misalign_calc = |ofs;
            end
        endcase
        strobe_calc = req_write ? (strobe_base << ofs) : '0;
        data_calc   = req_wdata << {ofs, 3'b000};
    end

    assign issue   = (state == IDLE) && req_valid && !misalign_calc;
    assign reject  = (state == IDLE) && req_valid && misalign_calc;
    assign capture = !write_r && dbus.dresp_data_ok &&
                     (((state == REQ) && dbus.dresp_addr_ok) || (state == WAIT));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; DONE only leaves on pipe_advance so an access is never re-issued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) state_nxt = misalign_calc ? DONE : REQ;
            end
            REQ: begin
                if (dbus.dresp_addr_ok) state_nxt = dbus.dresp_data_ok ? DONE : WAIT;
            end
            WAIT: begin
                if (dbus.dresp_data_ok) state_nxt = DONE;
            end
            DONE: begin
                if (pipe_advance) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request copies held stable on the bus while REQ waits for addr_ok.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r   <= '0;
            size_r   <= '0;
            strobe_r <= '0;
            data_r   <= '0;
            write_r  <= 1'b0;
        end else if (issue) begin
            addr_r   <= req_addr;
            size_r   <= req_msize;
            strobe_r <= strobe_calc;
            data_r   <= data_calc;
            write_r  <= req_write;
        end
    end

    // Misalign flag lives for the DONE visit; read data is captured only on load completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_r <= 1'b0;
            rd_raw_r   <= '0;
        end else begin
            if (reject)
                misalign_r <= 1'b1;
            else if ((state == DONE) && pipe_advance)
                misalign_r <= 1'b0;
            if (capture)
                rd_raw_r <= dbus.dresp_data;
        end
    end

    assign dbus.dreq_valid  = (state == REQ);
    assign dbus.dreq_addr   = addr_r;
    assign dbus.dreq_size   = size_r;
    assign dbus.dreq_strobe = strobe_r;
    assign dbus.dreq_data   = data_r;

    assign mem_stall = req_valid && (state != DONE);
    assign rd_raw    = rd_raw_r;
    assign misalign  = misalign_r;
endmodule

// File: tb/tb_memory_dbus_ctrl.sv
// Scoreboard bench for memory_dbus_ctrl: stimulus pushes expected bus requests
// and completions; a negedge monitor pops and compares when the DUT presents them.
module tb_memory_dbus_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_msize = 2'd0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        pipe_advance = 1'b0;
    logic        mem_stall;
    logic [63:0] rd_raw;
    logic        misalign;

    memory_dbus_ctrl_if #(.XLEN(64), .ADDR_W(64)) dbus ();

    memory_dbus_ctrl #(.XLEN(64), .ADDR_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_msize    (req_msize),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .pipe_advance (pipe_advance),
        .dbus         (dbus),
        .mem_stall    (mem_stall),
        .rd_raw       (rd_raw),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic        wr;
    } req_t;

    typedef struct {
        logic        mis;
        logic [63:0] rd;
    } done_t;

    req_t  exp_req_q[$];
    done_t exp_done_q[$];
    int    checks = 0;
    int    errors = 0;
    logic [63:0] exp_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: bus acceptances and access completions are checked against the queues.
    logic done_seen = 1'b0;
    always @(negedge clk) begin
        if (!reset && dbus.dreq_valid && dbus.dresp_addr_ok) begin
            if (exp_req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_request: got addr %h expected none", dbus.dreq_addr);
            end else begin
                req_t r;
                r = exp_req_q.pop_front();
                chk("req_addr", dbus.dreq_addr, r.addr);
                chk("req_size", 64'(dbus.dreq_size), 64'(r.size));
                chk("req_strobe", 64'(dbus.dreq_strobe), 64'(r.strobe));
                if (r.wr) chk("req_data", dbus.dreq_data, r.data);
            end
        end
        if (!req_valid) done_seen = 1'b0;
        else if (!reset && !mem_stall && !done_seen) begin
            done_seen = 1'b1;
            if (exp_done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got rd_raw %h expected none", rd_raw);
            end else begin
                done_t d;
                d = exp_done_q.pop_front();
                chk("done_misalign", 64'(misalign), 64'(d.mis));
                chk("done_rd_raw", rd_raw, d.rd);
            end
        end
    end

    // One M-stage access with a scripted bus: addr_ok after aok REQ cycles,
    // data_ok dok cycles after acceptance (0 = same cycle), then hold in DONE.
    task automatic run_txn(input string name, input logic wr, input logic [1:0] sz,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input int aok, input int dok, input logic [63:0] rdata,
                           input int hold, input logic mis,
                           input logic [7:0] e_strobe, input logic [63:0] e_data,
                           input int e_stall, input int e_vld);
        int stall_cnt = 0;
        int vld_cnt   = 0;
        int rc = 0;
        int wc = 0;
        bit accepted = 0;
        bit finished = 0;
        bit done = 0;
        logic [63:0] rd_hold;
        if (!mis) exp_req_q.push_back('{addr, sz, e_strobe, e_data, wr});
        if (!mis && !wr) exp_rd = rdata;
        exp_done_q.push_back('{mis, exp_rd});

        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_msize = sz; req_addr = addr; req_wdata = wdata;
        dbus.dresp_data = rdata;
        for (int c = 0; c < 50; c++) begin
            dbus.dresp_addr_ok = 1'b0;
            dbus.dresp_data_ok = 1'b0;
            if (dbus.dreq_valid) begin
                if (rc == aok) begin
                    dbus.dresp_addr_ok = 1'b1;
                    accepted = 1;
                    if (dok == 0) begin
                        dbus.dresp_data_ok = 1'b1;
                        finished = 1;
                    end
                end
                rc++;
            end else if (accepted && !finished) begin
                wc++;
                if (wc == dok) begin
                    dbus.dresp_data_ok = 1'b1;
                    finished = 1;
                end
            end
            @(negedge clk);
            if (!mem_stall) begin
                done = 1;
                break;
            end
            stall_cnt++;
            if (dbus.dreq_valid) vld_cnt++;
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got stall after 50 cycles expected completion", name);
        end
        chk({name, "_stall_cycles"}, 64'(stall_cnt), 64'(e_stall));
        chk({name, "_valid_cycles"}, 64'(vld_cnt), 64'(e_vld));

        rd_hold = exp_rd;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            dbus.dresp_data_ok = 1'b1;
            dbus.dresp_data = ~rdata;
            @(negedge clk);
            chk({name, "_hold_valid"}, 64'(dbus.dreq_valid), 64'd0);
            chk({name, "_hold_stall"}, 64'(mem_stall), 64'd0);
            chk({name, "_hold_rd_raw"}, rd_raw, rd_hold);
        end
        @(posedge clk); #1;
        dbus.dresp_data_ok = 1'b0;
        pipe_advance = 1'b1;
        @(posedge clk); #1;
        pipe_advance = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_after_misalign"}, 64'(misalign), 64'd0);
        chk({name, "_after_valid"}, 64'(dbus.dreq_valid), 64'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"}, 64'(dbus.dreq_valid), 64'd0);
        chk({name, "_addr"}, dbus.dreq_addr, 64'd0);
        chk({name, "_size"}, 64'(dbus.dreq_size), 64'd0);
        chk({name, "_strobe"}, 64'(dbus.dreq_strobe), 64'd0);
        chk({name, "_data"}, dbus.dreq_data, 64'd0);
        chk({name, "_stall"}, 64'(mem_stall), 64'd0);
        chk({name, "_rd_raw"}, rd_raw, 64'd0);
        chk({name, "_misalign"}, 64'(misalign), 64'd0);
    endtask

    initial begin
        dbus.dresp_addr_ok = 1'b0;
        dbus.dresp_data_ok = 1'b0;
        dbus.dresp_data    = '0;
        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // sb: strobe 0x08, data 0xAB<<24, stall 2, one valid cycle
        run_txn("sb", 1'b1, 2'd0, 64'h8000_0003, 64'hAB, 0, 0, 64'h5A5A_5A5A_5A5A_5A5A, 0,
                1'b0, 8'h08, 64'h0000_0000_AB00_0000, 2, 1);
        // ld: addr_ok after 3 cycles, data_ok 2 later: 4 valid cycles, stall 1+4+2
        run_txn("ld", 1'b0, 2'd3, 64'h8000_0010, 64'h0, 3, 2, 64'h1122_3344_5566_7788, 0,
                1'b0, 8'h00, 64'h0, 7, 4);
        // lh misaligned: no bus op, stall 1
        run_txn("lh_mis", 1'b0, 2'd1, 64'h8000_0001, 64'h0, 0, 0, 64'hFFFF_0000_FFFF_0000, 0,
                1'b1, 8'h00, 64'h0, 1, 0);
        // lw then DONE held 5 cycles with stray data_ok
        run_txn("lw", 1'b0, 2'd2, 64'h8000_0004, 64'h0, 1, 1, 64'hCAFE_BABE_1234_5678, 5,
                1'b0, 8'h00, 64'h0, 4, 2);
        // sd: full strobe, data unshifted, rd_raw untouched by store
        run_txn("sd", 1'b1, 2'd3, 64'h8, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 64'h0101_0101_0101_0101, 0,
                1'b0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 2, 1);
        // sh at offset 6: strobe 0xC0, data shifted into the top lanes
        run_txn("sh", 1'b1, 2'd1, 64'h6, 64'h1234, 1, 0, 64'h0, 0,
                1'b0, 8'hC0, 64'h1234_0000_0000_0000, 3, 2);
        // sw misaligned at offset 2
        run_txn("sw_mis", 1'b1, 2'd2, 64'h2, 64'h77, 0, 0, 64'h0, 0,
                1'b1, 8'h00, 64'h0, 1, 0);

        // reset while in WAIT: everything clears, a later data_ok is ignored
        exp_req_q.push_back('{64'h100, 2'd3, 8'h00, 64'h0, 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_msize = 2'd3; req_addr = 64'h100;
        @(posedge clk); #1;
        dbus.dresp_addr_ok = 1'b1;
        @(posedge clk); #1;
        dbus.dresp_addr_ok = 1'b0;
        @(negedge clk);
        chk("wait_stall", 64'(mem_stall), 64'd1);
        #2;
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        dbus.dresp_data_ok = 1'b1;
        dbus.dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        dbus.dresp_data_ok = 1'b0;
        @(negedge clk);
        chk("post_reset_rd_raw", rd_raw, 64'd0);
        chk("post_reset_valid", 64'(dbus.dreq_valid), 64'd0);
        chk("post_reset_stall", 64'(mem_stall), 64'd0);

        repeat (2) @(posedge clk);
        chk("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
